bbg_burst_ctrl: RTL

- Burst scheduler for the baseband generator chain.
- Produces the symbol strobe (cke) and data-enable window (den) that pace the bit/symbol generator and shaping filters.
- Sequences ramp-up, data, ramp-down and gap phases for a programmed number of bursts.
- Applies a linear power-ramp gain to the filtered I/Q before the LO mixer.

---
 rtl/bbg_burst_ctrl_pkg.sv | 22 ++
 rtl/bbg_burst_ctrl_if.sv | 34 +++
 rtl/bbg_burst_ctrl_sym_tick_gen.sv | 36 +++
 rtl/bbg_burst_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bbg_burst_ctrl_pkg.sv
// Shared types and constants for the baseband burst scheduler.
package bbg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    DATA,
    RAMP_DOWN,
    GAP
  } state_t;

  localparam logic [15:0] GAIN_MAX = 16'd32767;
  localparam int unsigned GAIN_SH  = 15;

  // Linear envelope point: k << (15 - sh), clamped to full scale.
  function automatic logic [15:0] ramp_gain(input logic [7:0] k, input logic [2:0] sh);
    logic [22:0] v;
    v = (23'(k) << GAIN_SH) >> sh;
    ramp_gain = (v > 23'(GAIN_MAX)) ? GAIN_MAX : 16'(v);
  endfunction

endpackage

// File: rtl/bbg_burst_ctrl_if.sv
// Control, configuration, I/Q and status bundle of the burst scheduler.
interface bbg_burst_ctrl_if #(
  parameter int DW  = 16,
  parameter int SDW = 16,
  parameter int LW  = 16
);
  logic                 start;
  logic                 stop;
  logic [SDW-1:0]       sym_div;
  logic [LW-1:0]        burst_len;
  logic [LW-1:0]        gap_len;
  logic [2:0]           ramp_sh;
  logic [7:0]           burst_num;
  logic signed [DW-1:0] i_in;
  logic signed [DW-1:0] q_in;
  logic signed [DW-1:0] i_out;
  logic signed [DW-1:0] q_out;
  logic                 cke;
  logic                 den;
  logic [15:0]          gain;
  logic                 busy;
  logic                 frame_sync;
  logic                 burst_done;

  modport master (
    output start, stop, sym_div, burst_len, gap_len, ramp_sh, burst_num, i_in, q_in,
    input  i_out, q_out, cke, den, gain, busy, frame_sync, burst_done
  );

  modport slave (
    input  start, stop, sym_div, burst_len, gap_len, ramp_sh, burst_num, i_in, q_in,
    output i_out, q_out, cke, den, gain, busy, frame_sync, burst_done
  );
endinterface

// File: rtl/bbg_burst_ctrl_sym_tick_gen.sv
// Loadable symbol-rate divider: tick on the first cycle after load, then every div+1 clocks.
module sym_tick_gen #(
  parameter int SDW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           load,
  input  logic [SDW-1:0] div,
  output logic           tick
);

  logic [SDW-1:0] period;
  logic [SDW-1:0] cnt;
  logic           run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (load) begin
      period <= div;
      cnt    <= '0;
      run    <= 1'b1;
    end else if (run) begin
      cnt <= (cnt == period) ? '0 : cnt + SDW'(1);
    end
  end

  assign tick = run && (cnt == '0);

endmodule

// File: rtl/bbg_burst_ctrl.sv
// Burst scheduler: symbol strobe, data window, burst sequencing and power-ramp gain on I/Q.
module bbg_burst_ctrl
  import bbg_pkg::*;
#(
  parameter int DW  = 16,
  parameter int SDW = 16,
  parameter int LW  = 16
) (
  input  logic           clk,
  input  logic           rst,
  bbg_burst_ctrl_if.slave bus
);

  state_t         state, state_n;
  logic [7:0]     k, k_n;
  logic [15:0]    gain_q, gain_n;
  logic [LW-1:0]  cnt, cnt_n;
  logic [7:0]     bcnt, bcnt_n;
  logic           fs_q, fs_n;
  logic           bd_q, bd_n;
  logic           stop_pend;
  logic           cke;

  logic [LW-1:0]  burst_len_q;
  logic [LW-1:0]  gap_len_q;
  logic [2:0]     ramp_sh_q;
  logic [7:0]     burst_num_q;

  logic           start_acc;
  logic           stop_eff;
  logic [LW-1:0]  blen_m1;
  logic [LW-1:0]  gap_m1;
  logic [7:0]     ramp_top;
  logic           last_burst;

  logic signed [DW+16:0] prod_i;
  logic signed [DW+16:0] prod_q;
  logic signed [DW-1:0]  i_q;
  logic signed [DW-1:0]  q_q;

  assign start_acc  = (state == IDLE) && bus.start && !bus.stop;
  assign stop_eff   = stop_pend || bus.stop;
  assign blen_m1    = (burst_len_q == '0) ? '0 : burst_len_q - LW'(1);
  assign gap_m1     = gap_len_q - LW'(1);
  assign ramp_top   = 8'd1 << ramp_sh_q;
  assign last_burst = (burst_num_q != 8'd0) && (bcnt == burst_num_q - 8'd1);

  sym_tick_gen #(.SDW(SDW)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (state_n == IDLE),
    .load  (start_acc),
    .div   (bus.sym_div),
    .tick  (cke)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_len_q <= '0;
      gap_len_q   <= '0;
      ramp_sh_q   <= '0;
      burst_num_q <= '0;
    end else if (start_acc) begin
      burst_len_q <= bus.burst_len;
      gap_len_q   <= bus.gap_len;
      ramp_sh_q   <= bus.ramp_sh;
      burst_num_q <= bus.burst_num;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      cnt       <= '0;
      bcnt      <= '0;
      gain_q    <= '0;
      fs_q      <= 1'b0;
      bd_q      <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      state  <= state_n;
      k      <= k_n;
      cnt    <= cnt_n;
      bcnt   <= bcnt_n;
      gain_q <= gain_n;
      fs_q   <= fs_n;
      bd_q   <= bd_n;
      if (state_n == IDLE)
        stop_pend <= 1'b0;
      else if (bus.stop)
        stop_pend <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    k_n     = k;
    cnt_n   = cnt;
    bcnt_n  = bcnt;
    gain_n  = gain_q;
    fs_n    = 1'b0;
    bd_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_acc) begin
          state_n = RAMP_UP;
          k_n     = '0;
          cnt_n   = '0;
          bcnt_n  = '0;
          gain_n  = '0;
        end
      end
      RAMP_UP: begin
        if (cke) begin
          if (stop_eff) begin
            state_n = RAMP_DOWN;
          end else begin
            k_n = k + 8'd1;
            if (k_n == ramp_top) begin
              state_n = DATA;
              gain_n  = GAIN_MAX;
              cnt_n   = '0;
              fs_n    = 1'b1;
            end else begin
              gain_n = ramp_gain(k_n, ramp_sh_q);
            end
          end
        end
      end
      DATA: begin
        if (cke) begin
          if (stop_eff || cnt == blen_m1)
            state_n = RAMP_DOWN;
          else
            cnt_n = cnt + LW'(1);
        end
      end
      RAMP_DOWN: begin
        if (cke) begin
          // k can already be 0 when a stop hit on the first ramp-up strobe.
          if (k <= 8'd1) begin
            k_n    = '0;
            gain_n = '0;
            bd_n   = 1'b1;
            cnt_n  = '0;
            if (stop_eff || last_burst) begin
              state_n = IDLE;
            end else begin
              if (burst_num_q != 8'd0)
                bcnt_n = bcnt + 8'd1;
              state_n = (gap_len_q == '0) ? RAMP_UP : GAP;
            end
          end else begin
            k_n    = k - 8'd1;
            gain_n = ramp_gain(k_n, ramp_sh_q);
          end
        end
      end
      GAP: begin
        if (cke) begin
          if (stop_eff) begin
            state_n = IDLE;
          end else if (cnt == gap_m1) begin
            state_n = RAMP_UP;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + LW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign prod_i = bus.i_in * $signed({1'b0, gain_q});
  assign prod_q = bus.q_in * $signed({1'b0, gain_q});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q <= '0;
      q_q <= '0;
    end else begin
      i_q <= DW'(prod_i >>> GAIN_SH);
      q_q <= DW'(prod_q >>> GAIN_SH);
    end
  end

  assign bus.i_out      = i_q;
  assign bus.q_out      = q_q;
  assign bus.cke        = cke;
  assign bus.den        = (state == DATA);
  assign bus.gain       = gain_q;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_sync = fs_q;
  assign bus.burst_done = bd_q;

endmodule
